// File: rtl/cmp_pkg.sv
// ============================================================================
// cmp_pkg : shared op encodings, FSM states and flag selection for cmp_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package cmp_pkg;

   localparam logic [2:0] OP_SLT  = 3'b000;
   localparam logic [2:0] OP_SGT  = 3'b001;
   localparam logic [2:0] OP_SLTU = 3'b010;
   localparam logic [2:0] OP_SGTU = 3'b011;
   localparam logic [2:0] OP_SEQ  = 3'b100;
   localparam logic [2:0] OP_SNE  = 3'b101;
   localparam logic [2:0] OP_SLE  = 3'b110;
   localparam logic [2:0] OP_SGE  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Equality ops are sign-agnostic, so treating them as signed is harmless.
   function automatic logic op_signed(input logic [2:0] op);
      return !(op == OP_SLTU || op == OP_SGTU);
   endfunction

   function automatic logic op_flag(input logic [2:0] op, input logic lt,
                                    input logic eq, input logic gt);
      logic flag;
      flag = 1'b0;
      case (op)
         OP_SLT, OP_SLTU: flag = lt;
         OP_SGT, OP_SGTU: flag = gt;
         OP_SEQ:          flag = eq;
         OP_SNE:          flag = !eq;
         OP_SLE:          flag = lt | eq;
         OP_SGE:          flag = gt | eq;
         default:         flag = 1'b0;
      endcase
      return flag;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_chunk.sv
// ============================================================================
// cmp_chunk : combinational CHUNK-bit unsigned compare, optional MSB flip
// Revision: 1.0
// ============================================================================
`default_nettype none

module cmp_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_c,
   input  logic [CHUNK-1:0] b_c,
   input  logic             invert_msb,
   output logic             c_lt,
   output logic             c_gt
);

   logic [CHUNK-1:0] msb_mask;
   logic [CHUNK-1:0] a_x;
   logic [CHUNK-1:0] b_x;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign msb_mask = invert_msb ? (CHUNK'(1) << (CHUNK - 1)) : '0;
   assign a_x      = a_c ^ msb_mask;
   assign b_x      = b_c ^ msb_mask;
   assign c_lt     = (a_x < b_x);
   assign c_gt     = (a_x > b_x);

endmodule

`default_nettype wire

// File: rtl/cmp_unit.sv
// ============================================================================
// cmp_unit : multi-cycle MSB-first chunked compare with valid/ready handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

module cmp_unit
   import cmp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int CHUNK      = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("cmp_unit: WIDTH must be a multiple of CHUNK");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [2:0]       op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             found_lt_q, found_lt_d, found_gt_q, found_gt_d;
   logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

   logic             c_lt, c_gt, new_lt, new_gt, scan_end;

   cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_c        (a_q[idx_q*CHUNK +: CHUNK]),
      .b_c        (b_q[idx_q*CHUNK +: CHUNK]),
      .invert_msb (op_signed(op_q) && (idx_q == IDX_TOP)),
      .c_lt       (c_lt),
      .c_gt       (c_gt)
   );

   // Only the most significant differing chunk decides the ordering.
   assign new_lt   = found_lt_q | (!found_lt_q && !found_gt_q && c_lt);
   assign new_gt   = found_gt_q | (!found_lt_q && !found_gt_q && c_gt);
   assign scan_end = (idx_q == '0) || ((EARLY_EXIT != 0) && (c_lt || c_gt));

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      idx_d      = idx_q;
      found_lt_d = found_lt_q;
      found_gt_d = found_gt_q;
      result_d   = result_q;
      lt_d       = lt_q;
      eq_d       = eq_q;
      gt_d       = gt_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d        = a;
               b_d        = b;
               op_d       = op;
               idx_d      = IDX_TOP;
               found_lt_d = 1'b0;
               found_gt_d = 1'b0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            found_lt_d = new_lt;
            found_gt_d = new_gt;
            idx_d      = idx_q - 1'b1;
            if (scan_end) begin
               idx_d    = IDX_TOP;
               lt_d     = new_lt;
               gt_d     = new_gt;
               eq_d     = !new_lt && !new_gt;
               result_d = WIDTH'(op_flag(op_q, new_lt, !new_lt && !new_gt, new_gt));
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d = ST_IDLE;
         idx_d   = IDX_TOP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         idx_q      <= IDX_TOP;
         found_lt_q <= 1'b0;
         found_gt_q <= 1'b0;
         result_q   <= '0;
         lt_q       <= 1'b0;
         eq_q       <= 1'b0;
         gt_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         idx_q      <= idx_d;
         found_lt_q <= found_lt_d;
         found_gt_q <= found_gt_d;
         result_q   <= result_d;
         lt_q       <= lt_d;
         eq_q       <= eq_d;
         gt_q       <= gt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign gt        = gt_q;

endmodule

`default_nettype wire
